// File: rtl/fib_recognizer.sv
// Registered Fibonacci recognizer for a 4-bit code, one-cycle latency.
// Define FIB_REC_COUNT_EN to enable the saturating hit counter on hit_count.
module fib_recognizer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       BCD_in,
  output logic             f,
  output logic             f_valid,
  output logic             bcd_err,
  output logic [2:0]       fib_idx,
  output logic [CNT_W-1:0] hit_count
);

  // Index 0 doubles as "not Fibonacci"; code 0 is the only Fibonacci value with index 0.
  function automatic logic [2:0] fib_index(input logic [3:0] code);
    logic [2:0] idx;
    case (code)
      4'd1:    idx = 3'd1;
      4'd2:    idx = 3'd3;
      4'd3:    idx = 3'd4;
      4'd5:    idx = 3'd5;
      4'd8:    idx = 3'd6;
      4'd13:   idx = 3'd7;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_fib(input logic [3:0] code);
    return (code == 4'd0) || (fib_index(code) != 3'd0);
  endfunction

  function automatic logic is_non_bcd(input logic [3:0] code);
    return code > 4'd9;
  endfunction

  logic       f_p1_d, f_p1_q;
  logic       bcd_err_p1_d, bcd_err_p1_q;
  logic [2:0] fib_idx_p1_d, fib_idx_p1_q;
  logic       vld_p1_d, vld_p1_q;

  // Stage p0 -> p1: classify on accepted samples, hold otherwise
  always_comb begin
    f_p1_d       = f_p1_q;
    bcd_err_p1_d = bcd_err_p1_q;
    fib_idx_p1_d = fib_idx_p1_q;
    vld_p1_d     = in_valid;
    if (in_valid) begin
      f_p1_d       = is_fib(BCD_in);
      bcd_err_p1_d = is_non_bcd(BCD_in);
      fib_idx_p1_d = fib_index(BCD_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_p1_q       <= 1'b0;
      bcd_err_p1_q <= 1'b0;
      fib_idx_p1_q <= 3'd0;
      vld_p1_q     <= 1'b0;
    end else begin
      f_p1_q       <= f_p1_d;
      bcd_err_p1_q <= bcd_err_p1_d;
      fib_idx_p1_q <= fib_idx_p1_d;
      vld_p1_q     <= vld_p1_d;
    end
  end

  assign f       = f_p1_q;
  assign bcd_err = bcd_err_p1_q;
  assign fib_idx = fib_idx_p1_q;
  assign f_valid = vld_p1_q;

`ifdef FIB_REC_COUNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
  endfunction

  logic [CNT_W-1:0] hit_cnt_p1_d, hit_cnt_p1_q;

  always_comb begin
    hit_cnt_p1_d = hit_cnt_p1_q;
    if (in_valid && is_fib(BCD_in)) hit_cnt_p1_d = sat_inc(hit_cnt_p1_q);
  end

  always_ff @(posedge clk) begin
    if (reset) hit_cnt_p1_q <= '0;
    else       hit_cnt_p1_q <= hit_cnt_p1_d;
  end

  assign hit_count = hit_cnt_p1_q;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_fib_recognizer.sv
// Scoreboard bench for fib_recognizer: stimulus pushes per-cycle expectations, monitor compares.
module tb_fib_recognizer;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [3:0]       BCD_in = 4'd0;
  logic             f, f_valid, bcd_err;
  logic [2:0]       fib_idx;
  logic [CNT_W-1:0] hit_count;

  fib_recognizer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .BCD_in(BCD_in),
    .f(f), .f_valid(f_valid), .bcd_err(bcd_err), .fib_idx(fib_idx),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic       f;
    logic       err;
    logic [2:0] idx;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Hand-written expected tables for codes 0..15
  int         idx_tab [16] = '{0, 1, 3, 4, 0, 5, 0, 0, 6, 0, 0, 0, 0, 7, 0, 0};
  logic       fib_tab [16] = '{1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
  logic       err_tab [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  // Model state
  logic       m_f = 1'b0, m_err = 1'b0;
  logic [2:0] m_idx = 3'd0;
  int         m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic v, input logic [3:0] code);
    exp_t e;
    reset    = rst;
    in_valid = v;
    BCD_in   = code;
    @(posedge clk);
    if (rst) begin
      m_f = 1'b0; m_err = 1'b0; m_idx = 3'd0; m_cnt = 0;
      e.vld = 1'b0;
    end else begin
      e.vld = v;
      if (v) begin
        m_f   = fib_tab[code];
        m_err = err_tab[code];
        m_idx = 3'(idx_tab[code]);
`ifdef FIB_REC_COUNT_EN
        if (fib_tab[code] && m_cnt < CNT_MAX) m_cnt++;
`endif
      end
    end
    e.f = m_f; e.err = m_err; e.idx = m_idx; e.cnt = m_cnt;
    q.push_back(e);
    #1;
  endtask

  // Monitor: compare DUT outputs against the expectation for the last edge
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("f_valid",   32'(f_valid),   32'(e.vld));
      check("f",         32'(f),         32'(e.f));
      check("bcd_err",   32'(bcd_err),   32'(e.err));
      check("fib_idx",   32'(fib_idx),   32'(e.idx));
      check("hit_count", 32'(hit_count), 32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0);
    // Reset overrides a valid sample
    cycle(1'b1, 1'b1, 4'd5);
    cycle(1'b0, 1'b0, 4'd5);
    // Full sweep, back-to-back
    for (int c = 0; c < 16; c++) cycle(1'b0, 1'b1, 4'(c));
    // Hold behaviour
    cycle(1'b0, 1'b1, 4'd8);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'd4);
    // Saturation run
    cycle(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'd3);
    // Mixed stream, then reset mid-stream
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b0, 1'b1, 4'd4);
    cycle(1'b0, 1'b1, 4'd9);
    cycle(1'b0, 1'b1, 4'd13);
    cycle(1'b0, 1'b1, 4'd7);
    cycle(1'b0, 1'b0, 4'd7);
    cycle(1'b1, 1'b1, 4'd13);
    cycle(1'b0, 1'b1, 4'd10);
    cycle(1'b0, 1'b0, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
